counter_2bits_monitor: RTL and testbench

//   Downstream checker for the 2-bit free-running counter. Samples the counter

---
 rtl/counter_2bits_monitor_if.sv | 53 +++++
 rtl/counter_2bits_monitor.sv | 155 +++++++++++++++
 tb/tb_counter_2bits_monitor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/counter_2bits_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_2bits_monitor_if
// Description : Bundle between a 2-bit free-running counter source and its
//               monitor. The master side (counter/bench) drives the sample
//               qualifier and value; the slave side (monitor) returns lock
//               status, event pulses and event counters.
// Ports       : cnt_valid  - counter_in is to be sampled this cycle
//               counter_in - value from the 2-bit counter
//               locked     - monitor is in LOCKED
//               wrap_pulse - one-cycle pulse on an accepted 3->0 step
//               err_pulse  - one-cycle pulse on a step that was not +1 mod 4
//               wrap_count - wraps since clear (modulo 2^WRAP_W)
//               err_count  - errors since clear (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_2bits_monitor_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
);

  logic              cnt_valid;
  logic [1:0]        counter_in;
  logic              locked;
  logic              wrap_pulse;
  logic              err_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;

  // Counter side: provides samples, observes monitor status.
  modport master (
    output cnt_valid,
    output counter_in,
    input  locked,
    input  wrap_pulse,
    input  err_pulse,
    input  wrap_count,
    input  err_count
  );

  // Monitor side: consumes samples, reports status.
  modport slave (
    input  cnt_valid,
    input  counter_in,
    output locked,
    output wrap_pulse,
    output err_pulse,
    output wrap_count,
    output err_count
  );

endinterface : counter_2bits_monitor_if
`default_nettype wire

// File: rtl/counter_2bits_monitor.sv
`default_nettype none
// ============================================================================
// Module      : counter_2bits_monitor
// Description : Downstream checker for a 2-bit free-running counter. Each
//               qualified clock it samples the counter value, checks that it
//               stepped +1 mod 4 from the previous sample, flags and counts
//               wrap-arounds (3->0) and sequence errors, and reports lock
//               status once LOCK_N consecutive good steps have been seen.
// Parameters  : LOCK_N - consecutive good steps needed to lock (1..15)
//               WRAP_W - width of wrap_count (wraps modulo 2^WRAP_W)
//               ERR_W  - width of err_count (saturates at all-ones)
// Ports       : clk    - clock, rising edge
//               clear  - synchronous active-high reset, highest priority
//               mon    - slave modport of counter_2bits_monitor_if
//                        (cnt_valid/counter_in in; locked, wrap_pulse,
//                        err_pulse, wrap_count, err_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_2bits_monitor #(
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  wire                       clk,
  input  wire                       clear,
  counter_2bits_monitor_if.slave    mon
);

  // good_run must be able to hold the value LOCK_N itself.
  localparam int GR_W = $clog2(LOCK_N + 1);

  // Number of matches already seen when the next match completes the run.
  localparam logic [GR_W-1:0] LOCK_LAST = GR_W'(LOCK_N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        prev;
  logic [GR_W-1:0]   good_run;

  logic              locked;
  logic              wrap_pulse;
  logic              err_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;

  // --------------------------------------------------------------------------
  // Step evaluation (combinational, only meaningful in TRACK/LOCKED)
  // --------------------------------------------------------------------------
  logic [1:0] exp_val;
  logic       step_ok;
  logic       step_wrap;
  logic       err_sat;

  always_comb begin
    exp_val   = prev + 2'd1;                 // 2-bit arithmetic: 3+1 = 0
    step_ok   = (mon.counter_in == exp_val);
    // A wrap is only a matching 3->0; a mismatching 0 never counts as one.
    step_wrap = step_ok && (prev == 2'd3);
    err_sat   = (err_count == {ERR_W{1'b1}});
  end

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      prev       <= 2'd0;
      good_run   <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      // Pulses last exactly one cycle; they are re-asserted below only when
      // this cycle's sample produces the corresponding event.
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      if (mon.cnt_valid) begin
        // prev tracks every sample, so a single glitch costs one error and
        // checking resumes from the glitched value.
        prev <= mon.counter_in;

        case (state)
          IDLE: begin
            // First sample only seeds prev; nothing to compare against.
            state <= TRACK;
          end

          TRACK: begin
            if (step_ok) begin
              good_run <= good_run + 1'b1;
              if (good_run == LOCK_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
              if (step_wrap) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + 1'b1;
              end
            end else begin
              err_pulse <= 1'b1;
              good_run  <= '0;
              if (!err_sat) begin
                err_count <= err_count + 1'b1;
              end
            end
          end

          LOCKED: begin
            if (step_ok) begin
              // good_run is frozen while locked.
              if (step_wrap) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + 1'b1;
              end
            end else begin
              // locked falls on the same edge err_pulse rises.
              state     <= TRACK;
              locked    <= 1'b0;
              err_pulse <= 1'b1;
              good_run  <= '0;
              if (!err_sat) begin
                err_count <= err_count + 1'b1;
              end
            end
          end

          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drive the interface from the registered outputs
  // --------------------------------------------------------------------------
  assign mon.locked     = locked;
  assign mon.wrap_pulse = wrap_pulse;
  assign mon.err_pulse  = err_pulse;
  assign mon.wrap_count = wrap_count;
  assign mon.err_count  = err_count;

endmodule : counter_2bits_monitor
`default_nettype wire

// File: tb/tb_counter_2bits_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_2bits_monitor
// Description : Self-checking bench for counter_2bits_monitor. A table of
//               {inputs, expected outputs} records covers reset, locking,
//               error in LOCKED, hold gaps and clear mid-run; hand-written
//               loops cover error-count saturation and wrap_count roll-over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_2bits_monitor;

  localparam int LOCK_N = 4;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 4;

  logic clk;
  logic clear;

  counter_2bits_monitor_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

  counter_2bits_monitor #(
    .LOCK_N (LOCK_N),
    .WRAP_W (WRAP_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        clr;
    logic        v;
    logic [1:0]  c;
    logic        lk;
    logic        wp;
    logic        ep;
    logic [7:0]  wc;
    logic [3:0]  ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, sample outputs 1 time unit after the
  // following rising edge.
  task automatic step(input logic clr, input logic v, input logic [1:0] c);
    @(negedge clk);
    clear          = clr;
    bus.cnt_valid  = v;
    bus.counter_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic lk, input logic wp,
                           input logic ep, input logic [7:0] wc,
                           input logic [3:0] ec);
    check({tag, ".locked"},     32'(bus.locked),     32'(lk));
    check({tag, ".wrap_pulse"}, 32'(bus.wrap_pulse), 32'(wp));
    check({tag, ".err_pulse"},  32'(bus.err_pulse),  32'(ep));
    check({tag, ".wrap_count"}, 32'(bus.wrap_count), 32'(wc));
    check({tag, ".err_count"},  32'(bus.err_count),  32'(ec));
  endtask

  initial begin
    clear          = 1'b1;
    bus.cnt_valid  = 1'b0;
    bus.counter_in = 2'd0;

    //                clr v  c     lk wp ep wc ec
    // Reset with a valid sample present: clear wins.
    vecs.push_back('{1'b1,1'b1,2'd2, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b1,1'b1,2'd2, 1'b0,1'b0,1'b0,8'd0,4'd0});
    // Lock on 0,1,2,3,0: first sample seeds, four good steps lock.
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd2, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd3, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,8'd1,4'd0});
    // Locked 1,2 then 0 -> error, unlock; the 2->0 is not a wrap.
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b1,1'b0,1'b0,8'd1,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd2, 1'b1,1'b0,1'b0,8'd1,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b0,1'b0,1'b1,8'd1,4'd1});
    // Re-track from 0: 1,2,3,0 relocks with a wrap.
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b0,1'b0,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd2, 1'b0,1'b0,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd3, 1'b0,1'b0,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,8'd2,4'd1});
    // Hold: locked on 1, five invalid cycles with junk, then valid 2.
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b0,2'd3, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b0,2'd0, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b0,2'd3, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b0,2'd1, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b0,2'd3, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd2, 1'b1,1'b0,1'b0,8'd2,4'd1});
    // Continue locked to 3, then clear with a valid 3 present.
    vecs.push_back('{1'b0,1'b1,2'd3, 1'b1,1'b0,1'b0,8'd2,4'd1});
    vecs.push_back('{1'b1,1'b1,2'd3, 1'b0,1'b0,1'b0,8'd0,4'd0});
    // After clear: 0 only seeds (no error, no wrap from the old 3), 1 tracks.
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,8'd0,4'd0});
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b0,1'b0,1'b0,8'd0,4'd0});
    // Invalid cycle drops nothing and adds no pulse.
    vecs.push_back('{1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,8'd0,4'd0});
    // Glitch in TRACK (1 -> 3) is an error and resets the run; 0 then
    // follows 3 correctly and is a wrap even while not locked.
    vecs.push_back('{1'b0,1'b1,2'd3, 1'b0,1'b0,1'b1,8'd0,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd0, 1'b0,1'b1,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd1, 1'b0,1'b0,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd2, 1'b0,1'b0,1'b0,8'd1,4'd1});
    vecs.push_back('{1'b0,1'b1,2'd3, 1'b1,1'b0,1'b0,8'd1,4'd1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].v, vecs[i].c);
      check_all($sformatf("vec%0d", i), vecs[i].lk, vecs[i].wp, vecs[i].ep,
                vecs[i].wc, vecs[i].ec);
    end

    // ---- Saturation: 20 alternating samples 0,2,0,2,... ----
    step(1'b1, 1'b0, 2'd0);
    check_all("sat_clear", 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    step(1'b0, 1'b1, 2'd0);
    check_all("sat_seed", 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    for (int k = 1; k < 20; k++) begin
      step(1'b0, 1'b1, (k % 2 == 1) ? 2'd2 : 2'd0);
      check_all($sformatf("sat%0d", k), 1'b0, 1'b0, 1'b1, 8'd0,
                4'((k > 15) ? 15 : k));
    end
    step(1'b0, 1'b0, 2'd0);
    check_all("sat_idle", 1'b0, 1'b0, 1'b0, 8'd0, 4'd15);

    // ---- wrap_count roll-over after 256 wraps ----
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    for (int w = 1; w <= 256; w++) begin
      step(1'b0, 1'b1, 2'd1);
      step(1'b0, 1'b1, 2'd2);
      step(1'b0, 1'b1, 2'd3);
      step(1'b0, 1'b1, 2'd0);
      check($sformatf("wrap%0d.wrap_pulse", w), 32'(bus.wrap_pulse), 32'd1);
      check($sformatf("wrap%0d.wrap_count", w), 32'(bus.wrap_count),
            32'(w % 256));
    end
    check_all("wrap_end", 1'b1, 1'b1, 1'b0, 8'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_counter_2bits_monitor
`default_nettype wire
